keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/keypad_scan_ctrl_sync.sv | 28 ++
 rtl/keypad_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [3:0] ROW_IDLE = 4'b1110;
    localparam logic [3:0] COL_NONE = 4'hF;

    // Row-major key codes, indexed by {row_idx, col_index}.
    localparam logic [3:0] KEYMAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // True when exactly one column line is pulled low.
    function automatic logic single_low(input logic [3:0] c);
        int zeros;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!c[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    // Bit position of the low column; only meaningful when single_low() holds.
    function automatic logic [1:0] col_index(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
//
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync2 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: row scan, column debounce, one code per press.
// Latency: keyboard_en fires DEBOUNCE_CYC+1 cycles after the scan sample point.
// Backpressure: none; keyboard_en is a single-cycle strobe with no ready.
//
// Ports: clk, rst (sync, active-high), col (async active-low columns),
//        row (one-hot active-low drive), keyboard_en (press strobe),
//        keyboard_num (key code, held until next press), key_held.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       keyboard_en,
    output logic [3:0] keyboard_num,
    output logic       key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    logic [3:0]    col_s;

    state_t        state,     state_nxt;
    logic [SW-1:0] dwell_cnt, dwell_nxt;
    logic [DW-1:0] deb_cnt,   deb_nxt;
    logic [1:0]    row_idx,   row_idx_nxt;
    logic [3:0]    lat_col,   lat_col_nxt;
    logic [3:0]    row_nxt;
    logic          en_nxt;
    logic [3:0]    num_nxt;
    logic          held_nxt;

    sync2 #(
        .WIDTH   (4),
        .RST_VAL (COL_NONE)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (col_s)
    );

    always_comb begin
        state_nxt   = state;
        dwell_nxt   = dwell_cnt;
        deb_nxt     = deb_cnt;
        row_idx_nxt = row_idx;
        lat_col_nxt = lat_col;
        en_nxt      = 1'b0;
        num_nxt     = keyboard_num;
        held_nxt    = key_held;

        unique case (state)
            SCAN: begin
                if (dwell_cnt == SCAN_LAST) begin
                    dwell_nxt = '0;
                    // Multi-column patterns are ambiguous (ghosting), so
                    // they are treated like an idle row and skipped.
                    if (single_low(col_s)) begin
                        lat_col_nxt = col_s;
                        deb_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (col_s == lat_col) begin
                    if (deb_cnt == DEB_LAST) begin
                        // Outputs are registered on entry to PRESSED so the
                        // strobe and code are high exactly during that cycle.
                        deb_nxt   = '0;
                        en_nxt    = 1'b1;
                        num_nxt   = KEYMAP[{row_idx, col_index(lat_col)}];
                        held_nxt  = 1'b1;
                        state_nxt = PRESSED;
                    end else begin
                        deb_nxt = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_nxt     = '0;
                    dwell_nxt   = '0;
                    row_idx_nxt = row_idx + 2'd1;
                    state_nxt   = SCAN;
                end
            end

            PRESSED: begin
                deb_nxt   = '0;
                state_nxt = HOLD;
            end

            HOLD: begin
                // Row stays frozen; wait for a debounced all-released pattern.
                if (col_s == COL_NONE) begin
                    if (deb_cnt == DEB_LAST) begin
                        deb_nxt     = '0;
                        dwell_nxt   = '0;
                        held_nxt    = 1'b0;
                        row_idx_nxt = row_idx + 2'd1;
                        state_nxt   = SCAN;
                    end else begin
                        deb_nxt = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_nxt = '0;
                end
            end

            default: begin
                state_nxt = SCAN;
            end
        endcase

        row_nxt = ~(4'b0001 << row_idx_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SCAN;
            dwell_cnt    <= '0;
            deb_cnt      <= '0;
            row_idx      <= 2'd0;
            lat_col      <= COL_NONE;
            row          <= ROW_IDLE;
            keyboard_en  <= 1'b0;
            keyboard_num <= 4'h0;
            key_held     <= 1'b0;
        end else begin
            state        <= state_nxt;
            dwell_cnt    <= dwell_nxt;
            deb_cnt      <= deb_nxt;
            row_idx      <= row_idx_nxt;
            lat_col      <= lat_col_nxt;
            row          <= row_nxt;
            keyboard_en  <= en_nxt;
            keyboard_num <= num_nxt;
            key_held     <= held_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CYC=8.
// Timeline k counts clock edges since the last reset edge; all expected
// cycles below are hand-derived from that timeline (col_s lags col by 2).
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic       keyboard_en;
    logic [3:0] keyboard_num;
    logic       key_held;

    // Keypad model: one switch closure joining row press_row to the
    // columns low in press_pat.
    logic       press_on;
    logic [1:0] press_row;
    logic [3:0] press_pat;
    logic [3:0] sel_row;

    int cyc = 0;
    int r0  = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    int dbl_cnt   = 0;
    logic prev_en = 1'b0;

    assign sel_row = ~(4'b0001 << press_row);
    assign col     = (press_on && row == sel_row) ? press_pat : 4'hF;

    keypad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col          (col),
        .row          (row),
        .keyboard_en  (keyboard_en),
        .keyboard_num (keyboard_num),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (keyboard_en === 1'b1) begin
            pulse_cnt++;
            if (prev_en) dbl_cnt++;
        end
        prev_en = (keyboard_en === 1'b1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to #1 after edge k of the current timeline.
    task automatic wait_to(input int k);
        while ((cyc - r0) < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic on, input logic [1:0] r, input logic [3:0] pat);
        press_on  = on;
        press_row = r;
        press_pat = pat;
    endtask

    initial begin
        logic [3:0] exp_row;
        int low_cnt;

        rst = 1'b1;
        key(1'b0, 2'd0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_row",  {28'd0, row}, 32'hE);
        check_val("reset_en",   {31'd0, keyboard_en}, 32'd0);
        check_val("reset_num",  {28'd0, keyboard_num}, 32'd0);
        check_val("reset_held", {31'd0, key_held}, 32'd0);
        rst = 1'b0;
        r0  = cyc;

        // 1: idle scan, new row every 4 cycles.
        for (int k = 0; k <= 64; k += 4) begin
            wait_to(k);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check_val("idle_row", {28'd0, row}, {28'd0, exp_row});
        end
        check_val("idle_pulses", pulse_cnt, 0);

        // 2: key '5' (row 1, column 1). Sample at k=71, strobe at 71+9=80.
        key(1'b1, 2'd1, 4'b1101);
        wait_to(79);
        check_val("k5_pre_en", {31'd0, keyboard_en}, 32'd0);
        wait_to(80);
        check_val("k5_en",   {31'd0, keyboard_en}, 32'd1);
        check_val("k5_num",  {28'd0, keyboard_num}, 32'h5);
        check_val("k5_held", {31'd0, key_held}, 32'd1);
        wait_to(81);
        check_val("k5_post_en", {31'd0, keyboard_en}, 32'd0);
        wait_to(90);
        check_val("k5_row_frozen", {28'd0, row}, 32'hD);
        wait_to(94);
        key(1'b0, 2'd1, 4'hF);
        // col_s idle from 96; 8 stable cycles release at edge 104.
        wait_to(103);
        check_val("k5_held_late", {31'd0, key_held}, 32'd1);
        wait_to(104);
        check_val("k5_released", {31'd0, key_held}, 32'd0);
        check_val("k5_row_next", {28'd0, row}, 32'hB);
        check_val("k5_pulses", pulse_cnt, 1);

        // 3: key 'F' (row 3, column 2) bouncing every 3 cycles from 108..119.
        // Sample 111 enters DEBOUNCE, bounce aborts it at 114 (row 0),
        // clean sample at 129, strobe at 138.
        wait_to(108); key(1'b1, 2'd3, 4'b1011);
        wait_to(111); press_on = 1'b0;
        wait_to(114);
        check_val("kf_bounce_abort_row", {28'd0, row}, 32'hE);
        press_on = 1'b1;
        wait_to(117); press_on = 1'b0;
        wait_to(120); press_on = 1'b1;
        wait_to(137);
        check_val("kf_no_early_pulse", pulse_cnt, 1);
        wait_to(138);
        check_val("kf_en",  {31'd0, keyboard_en}, 32'd1);
        check_val("kf_num", {28'd0, keyboard_num}, 32'hF);
        wait_to(140);
        key(1'b0, 2'd3, 4'hF);
        wait_to(150);
        check_val("kf_released", {31'd0, key_held}, 32'd0);
        check_val("kf_pulses", pulse_cnt, 2);

        // 4: two columns low on row 0 is ignored; scan keeps moving.
        key(1'b1, 2'd0, 4'b1001);
        wait_to(154);
        check_val("ghost_row1", {28'd0, row}, 32'hD);
        wait_to(166);
        check_val("ghost_row0", {28'd0, row}, 32'hE);
        wait_to(170);
        check_val("ghost_row1b", {28'd0, row}, 32'hD);
        wait_to(190);
        check_val("ghost_pulses", pulse_cnt, 2);
        key(1'b0, 2'd0, 4'hF);

        // 5: key '1' (row 0, column 0) held 200 cycles. Sample 201, strobe 210.
        key(1'b1, 2'd0, 4'b1110);
        wait_to(210);
        check_val("k1_en",  {31'd0, keyboard_en}, 32'd1);
        check_val("k1_num", {28'd0, keyboard_num}, 32'h1);
        low_cnt = 0;
        for (int k = 210; k < 400; k++) begin
            wait_to(k);
            if (key_held !== 1'b1) low_cnt++;
        end
        check_val("k1_held_throughout", low_cnt, 0);
        check_val("k1_no_repeat", pulse_cnt, 3);
        key(1'b0, 2'd0, 4'hF);
        wait_to(410);
        check_val("k1_released", {31'd0, key_held}, 32'd0);
        check_val("k1_row_next", {28'd0, row}, 32'hD);

        // 6: key 'C' (row 2, column 3); sample 417, DEBOUNCE 418..425.
        key(1'b1, 2'd2, 4'b0111);
        wait_to(420);
        check_val("kc_row_frozen", {28'd0, row}, 32'hB);
        rst = 1'b1;
        key(1'b0, 2'd2, 4'hF);
        wait_to(421);
        check_val("rst_row",  {28'd0, row}, 32'hE);
        check_val("rst_en",   {31'd0, keyboard_en}, 32'd0);
        check_val("rst_held", {31'd0, key_held}, 32'd0);
        check_val("rst_num",  {28'd0, keyboard_num}, 32'd0);
        rst = 1'b0;
        r0  = cyc;
        wait_to(4);
        check_val("rst_scan_resumes", {28'd0, row}, 32'hD);
        wait_to(60);
        check_val("rst_no_pulse", pulse_cnt, 3);
        check_val("no_double_en", dbl_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
